// File: rtl/seg_mux_scheduler.sv
// seg_mux_scheduler: two-digit anode scan with a blanking gap at the start of each slot
module seg_mux_scheduler #(
    parameter int SLOT_CYCLES  = 24_000,
    parameter int BLANK_CYCLES = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [3:0] num,
    output logic [1:0] an,
    output logic       frame_tick
);
    localparam int CW = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] S_LAST = CW'(SLOT_CYCLES - 1);
    typedef enum logic [1:0] {BLANK0, SHOW0, BLANK1, SHOW1} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic blank, slot_end;
    always_comb begin
        blank    = state == BLANK0 || state == BLANK1;
        slot_end = cnt == S_LAST;
        state_nx = !en ? BLANK0 :
                   ((blank && cnt == B_LAST) || (!blank && slot_end)) ? state_t'(state + 2'd1) : state;
        cnt_nx   = (!en || (!blank && slot_end)) ? '0 : cnt + 1'b1;
        an       = state == SHOW0 ? 2'b10 : state == SHOW1 ? 2'b01 : 2'b11;
    end
    // num latches the digit value during blanking so it is settled before the anode turns on
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BLANK0;
            cnt        <= '0;
            num        <= 4'h0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            num        <= (!en || state == BLANK0) ? s0 : state == BLANK1 ? s1 : num;
            frame_tick <= en && state == SHOW1 && slot_end;
        end
    end
endmodule

// File: tb/tb_seg_mux_scheduler.sv
// tb_seg_mux_scheduler: directed and random scan checks against a frame-position reference model
module tb_seg_mux_scheduler;
    localparam int S = 10;
    localparam int B = 2;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [3:0] s0 = 4'h0;
    logic [3:0] s1 = 4'h0;
    logic [3:0] num;
    logic [1:0] an;
    logic       frame_tick;
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t = 0;
    int since = 0;
    bit spaced = 1'b0;
    logic [3:0] m_num = 4'h0;
    logic       m_tick = 1'b0;

    seg_mux_scheduler #(.SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .en(en), .s0(s0), .s1(s1),
        .num(num), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // t is the position within a 2S-cycle frame; blanking is the first B cycles of each half
    task automatic step();
        bit r, e;
        logic [1:0] m_an;
        @(posedge clk);
        r = reset;
        e = en;
        if (r) begin
            t = 0; m_num = 4'h0; m_tick = 1'b0;
        end else if (!e) begin
            t = 0; m_num = s0; m_tick = 1'b0;
        end else begin
            m_tick = (t == 2*S - 1);
            if (t % S < B) m_num = (t < S) ? s0 : s1;
            t = (t + 1) % (2*S);
        end
        m_an = (t % S < B) ? 2'b11 : (t < S) ? 2'b10 : 2'b01;
        #1;
        cyc++;
        chk("an", 8'(an), 8'(m_an));
        chk("num", 8'(num), 8'(m_num));
        chk("frame_tick", 8'(frame_tick), 8'(m_tick));
        chk("an_legal", 8'(an == 2'b00), 8'h0);
        since++;
        if (frame_tick === 1'b1) begin
            if (spaced) chk("tick_spacing", 8'(since), 8'(2*S));
            spaced = 1'b1;
            since = 0;
        end
        if (r || !e) spaced = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
        en = 1'b1;
        cyc = 0;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s0 = 4'($urandom); s1 = 4'($urandom); en = 1'($urandom);
            step();
            chk("rst_an", 8'(an), 8'h3);
            chk("rst_num", 8'(num), 8'h0);
            chk("rst_tick", 8'(frame_tick), 8'h0);
        end
        s0 = 4'h3; s1 = 4'hA;
        do_reset(1);
        for (int i = 0; i < 42; i++) begin
            step();
            if (cyc == 2)  chk("nom_show0", 8'({an, num}), 8'h23);
            if (cyc == 11) chk("nom_blank1", 8'(an), 8'h3);
            if (cyc == 12) chk("nom_show1", 8'({an, num}), 8'h1A);
            if (cyc == 19) chk("nom_tick19", 8'(frame_tick), 8'h0);
            if (cyc == 20) chk("nom_tick20", 8'(frame_tick), 8'h1);
            if (cyc == 40) chk("nom_tick40", 8'(frame_tick), 8'h1);
        end
        s0 = 4'h3;
        do_reset(1);
        for (int i = 0; i < 30; i++) begin
            if (cyc == 5) s0 = 4'h7;
            step();
            if (cyc == 9)  chk("hold_num9", 8'(num), 8'h3);
            if (cyc == 22) chk("hold_show0", 8'({an, num}), 8'h27);
        end
        do_reset(1);
        for (int i = 0; i < 40; i++) begin
            if (cyc == 14) en = 1'b0;
            if (cyc == 18) en = 1'b1;
            step();
            if (cyc == 15) chk("endrop_an15", 8'(an), 8'h3);
            if (cyc == 19) chk("endrop_an19", 8'(an), 8'h3);
            if (cyc == 20) chk("endrop_an20", 8'(an), 8'h2);
            if (cyc >= 15 && cyc <= 24) chk("endrop_notick", 8'(frame_tick), 8'h0);
        end
        do_reset(1);
        for (int i = 0; i < 30; i++) begin
            reset = (cyc == 5);
            step();
            if (cyc == 6) chk("midrst_c6", 8'({an, num}), 8'h30);
            if (cyc == 7) chk("midrst_c7", 8'(an), 8'h3);
            if (cyc == 8) chk("midrst_c8", 8'(an), 8'h2);
            if (cyc == 26) chk("midrst_tick", 8'(frame_tick), 8'h1);
        end
        reset = 1'b0;
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            reset = (r < 3);
            en = !(r >= 3 && r < 15);
            s0 = 4'($urandom);
            s1 = 4'($urandom);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
